// File: rtl/inv_search_solver_if.sv
// inv_search_solver_if: request/result handshake bundle for inv_search_solver
// Ports (master = requester/consumer, slave = solver):
//   in_valid/in_ready  request handshake carrying t, op, fn
//   out_valid/out_ready result handshake carrying x, sat, checks
interface inv_search_solver_if #(parameter int W = 4);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] t;
   logic [1:0]   op;
   logic         fn;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] x;
   logic         sat;
   logic [W:0]   checks;
   modport master (output in_valid, t, op, fn, out_ready,
                   input  in_ready, out_valid, x, sat, checks);
   modport slave  (input  in_valid, t, op, fn, out_ready,
                   output in_ready, out_valid, x, sat, checks);
endinterface

// File: rtl/inv_search_solver.sv
// inv_search_solver: finds the smallest unsigned x with op(fn(x), t) by linear search
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of inv_search_solver_if (request in, result out)
module inv_search_solver #(parameter int W = 4) (
   input  logic              clk,
   input  logic              rst_n,
   inv_search_solver_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
   state_t       state_q, state_d;
   logic [W-1:0] t_q, t_d, cand_q, cand_d, fx_q, fx_d, x_q, x_d;
   logic [1:0]   op_q, op_d;
   logic         fn_q, fn_d, ld_q, ld_d, sat_q, sat_d, hit;
   logic [W:0]   checks_q, checks_d;
   function automatic logic [W-1:0] fn_of(input logic f, input logic [W-1:0] v);
      return f ? ~v : -v;
   endfunction
   // fn(cand) is registered in fx_q so the negation adder stays off the compare path;
   // ld_q marks that fx_q holds fn(cand_q), costing one fill cycle per request
   assign hit = op_q[1] ? (op_q[0] ? fx_q > t_q : fx_q >= t_q)
                        : (op_q[0] ? $signed(fx_q) > $signed(t_q) : $signed(fx_q) >= $signed(t_q));
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      op_d     = op_q;
      fn_d     = fn_q;
      cand_d   = cand_q;
      fx_d     = fx_q;
      ld_d     = ld_q;
      x_d      = x_q;
      sat_d    = sat_q;
      checks_d = checks_q;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            t_d      = bus.t;
            op_d     = bus.op;
            fn_d     = bus.fn;
            cand_d   = '0;
            checks_d = '0;
            ld_d     = 1'b0;
            state_d  = SEARCH;
         end
         SEARCH: if (!ld_q) begin
            fx_d = fn_of(fn_q, cand_q);
            ld_d = 1'b1;
         end else begin
            checks_d = checks_q + 1'b1;
            if (hit) begin
               x_d     = cand_q;
               sat_d   = 1'b1;
               state_d = DONE;
            end else if (&cand_q) begin
               x_d     = '0;
               sat_d   = 1'b0;
               state_d = DONE;
            end else begin
               cand_d = cand_q + 1'b1;
               fx_d   = fn_of(fn_q, cand_q + 1'b1);
            end
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         t_q      <= '0;
         op_q     <= '0;
         fn_q     <= 1'b0;
         cand_q   <= '0;
         fx_q     <= '0;
         ld_q     <= 1'b0;
         x_q      <= '0;
         sat_q    <= 1'b0;
         checks_q <= '0;
      end else begin
         state_q  <= state_d;
         t_q      <= t_d;
         op_q     <= op_d;
         fn_q     <= fn_d;
         cand_q   <= cand_d;
         fx_q     <= fx_d;
         ld_q     <= ld_d;
         x_q      <= x_d;
         sat_q    <= sat_d;
         checks_q <= checks_d;
      end
   end
   assign bus.in_ready  = state_q == IDLE;
   assign bus.out_valid = state_q == DONE;
   assign bus.x         = x_q;
   assign bus.sat       = sat_q;
   assign bus.checks    = checks_q;
endmodule

// File: tb/tb_inv_search_solver.sv
// tb_inv_search_solver: directed and random checks of inv_search_solver against a search model
module tb_inv_search_solver;
   localparam int W = 4;
   localparam int M = 1 << W;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   inv_search_solver_if #(.W(W)) bus();
   inv_search_solver #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   // brute-force search straight from the predicate definitions
   function automatic void ref_solve(input int tv, input int o, input int f,
                                     output int xs, output int s, output int c);
      xs = 0;
      s  = 0;
      c  = M;
      for (int k = 0; k < M; k++) begin
         int fx = f ? (M - 1 - k) : (M - k) % M;
         int a  = fx >= M / 2 ? fx - M : fx;
         int b  = tv >= M / 2 ? tv - M : tv;
         bit h  = o == 0 ? a >= b : o == 1 ? a > b : o == 2 ? fx >= tv : fx > tv;
         if (h) begin
            xs = k;
            s  = 1;
            c  = k + 1;
            return;
         end
      end
   endfunction

   // issue one request and wait (bounded) for the result; lat counts edges after the accept edge
   task automatic run_req(input logic [W-1:0] tt, input logic [1:0] oo, input logic ff,
                          output int lat, output logic [W-1:0] xo, output logic so,
                          output logic [W:0] co);
      bus.t = tt;
      bus.op = oo;
      bus.fn = ff;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!bus.out_valid && lat < M + 8);
      xo = bus.x;
      so = bus.sat;
      co = bus.checks;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      n_cmp++;
      if ({bus.out_valid, bus.x, bus.sat, bus.checks} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got ov=%b x=%h sat=%b checks=%0d want all 0", bus.out_valid, bus.x, bus.sat, bus.checks);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release got rdy=%b ov=%b want 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] tv[5] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'hF};
      logic [1:0]   ov[5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
      logic         fv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] xe[5] = '{4'h0, 4'h9, 4'h8, 4'h0, 4'h0};
      logic         se[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [W:0]   ce[5] = '{5'd1, 5'd10, 5'd9, 5'd16, 5'd16};
      int lat;
      logic [W-1:0] xo;
      logic so;
      logic [W:0] co;
      for (int i = 0; i < 5; i++) begin
         run_req(tv[i], ov[i], fv[i], lat, xo, so, co);
         n_cmp++;
         if (lat !== int'(ce[i]) + 1) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, int'(ce[i]) + 1); end
         n_cmp++;
         if ({xo, so, co} !== {xe[i], se[i], ce[i]}) begin
            n_err++;
            $display("FAIL dir%0d_result got x=%h sat=%b checks=%0d want x=%h sat=%b checks=%0d", i, xo, so, co, xe[i], se[i], ce[i]);
         end
         drain();
      end
   endtask

   task automatic test_random();
      int lat, xs, s, c, tv, o, f;
      logic [W-1:0] xo;
      logic so;
      logic [W:0] co;
      for (int i = 0; i < 40; i++) begin
         tv = int'($urandom_range(M - 1));
         o  = int'($urandom_range(3));
         f  = int'($urandom_range(1));
         ref_solve(tv, o, f, xs, s, c);
         run_req(W'(tv), 2'(o), 1'(f), lat, xo, so, co);
         n_cmp++;
         if (xo !== W'(xs) || so !== 1'(s) || co !== (W+1)'(c) || lat !== c + 1) begin
            n_err++;
            $display("FAIL rand%0d t=%h op=%0d fn=%0d got x=%h sat=%b checks=%0d lat=%0d want x=%h sat=%0d checks=%0d lat=%0d",
                     i, tv, o, f, xo, so, co, lat, xs, s, c, c + 1);
         end
         if ($urandom_range(1) == 1) begin
            @(posedge clk);
            #1;
         end
         drain();
      end
   endtask

   task automatic test_hold();
      int lat;
      bus.t = 4'h5;
      bus.op = 2'd0;
      bus.fn = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.t = 4'h0;
      bus.op = 2'd2;
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
         bus.in_valid = lat < 3;
      end while (!bus.out_valid && lat < M + 8);
      n_cmp++;
      if (lat !== 11 || bus.x !== 4'h9 || bus.checks !== 5'd10) begin
         n_err++;
         $display("FAIL hold_search got lat=%0d x=%h checks=%0d want 11/9/10", lat, bus.x, bus.checks);
      end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.t = W'($urandom);
         @(posedge clk);
         #1;
         n_cmp++;
         if ({bus.out_valid, bus.in_ready, bus.x, bus.sat, bus.checks} !== {1'b1, 1'b0, 4'h9, 1'b1, 5'd10}) begin
            n_err++;
            $display("FAIL hold_stable%0d got ov=%b rdy=%b x=%h sat=%b checks=%0d want 1/0/9/1/10",
                     i, bus.out_valid, bus.in_ready, bus.x, bus.sat, bus.checks);
         end
      end
      bus.in_valid = 1'b0;
      drain();
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL hold_release got rdy=%b ov=%b want 1/0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [W-1:0] xo;
      logic so;
      logic [W:0] co;
      run_req(4'h3, 2'd2, 1'b1, lat, xo, so, co);
      n_cmp++;
      if (xo !== 4'h0 || co !== 5'd1) begin n_err++; $display("FAIL b2b_first got x=%h checks=%0d want 0/1", xo, co); end
      bus.t = 4'h0;
      bus.op = 2'd0;
      bus.fn = 1'b0;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_no_accept_on_release got rdy=%b want 1", bus.in_ready); end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept got rdy=%b want 0", bus.in_ready); end
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!bus.out_valid && lat < M + 8);
      n_cmp++;
      if (lat !== 2 || bus.x !== 4'h0 || bus.sat !== 1'b1 || bus.checks !== 5'd1) begin
         n_err++;
         $display("FAIL b2b_second got lat=%0d x=%h sat=%b checks=%0d want 2/0/1/1", lat, bus.x, bus.sat, bus.checks);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [W-1:0] xo;
      logic so;
      logic [W:0] co;
      bus.t = 4'h5;
      bus.op = 2'd0;
      bus.fn = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.x, bus.sat, bus.checks} !== {1'b1, 1'b0, 4'h0, 1'b0, 5'd0}) begin
         n_err++;
         $display("FAIL midreset_async got rdy=%b ov=%b x=%h sat=%b checks=%0d want 1/0/0/0/0",
                  bus.in_ready, bus.out_valid, bus.x, bus.sat, bus.checks);
      end
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_req(4'h5, 2'd0, 1'b0, lat, xo, so, co);
      n_cmp++;
      if (lat !== 11 || xo !== 4'h9 || so !== 1'b1 || co !== 5'd10) begin
         n_err++;
         $display("FAIL midreset_rerun got lat=%0d x=%h sat=%b checks=%0d want 11/9/1/10", lat, xo, so, co);
      end
      drain();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.t = '0;
      bus.op = '0;
      bus.fn = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
